// File: rtl/lc3b_mem_responder.sv
// rtl/lc3b_mem_responder.sv - LC-3b memory port responder with fixed programmable latency
// Optional per-op completion counters behind LC3B_MEM_STATS_EN.
module lc3b_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_wmask,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
  output logic [15:0] mem_rdata,
  output logic        proto_err
`ifdef LC3B_MEM_STATS_EN
  ,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic [15:0]             wdata_q;
  logic [1:0]              wmask_q;
  logic                    wr_q;
  logic [15:0]             rdata_q;
  logic                    perr_q;
  logic [15:0]             mem_q [0:DEPTH-1];

  logic                    req;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    rd_load;
  logic                    unused_addr;

  assign req         = mem_read | mem_write;
  assign accept      = (state_q == IDLE) && req;
  assign in_idx      = mem_address[ADDR_WIDTH:1];
  assign unused_addr = ^{mem_address[0], mem_address >> (ADDR_WIDTH + 1)};

  // Read data is fetched on the edge entering RESP so it is registered during the pulse.
  assign rd_idx  = (state_q == IDLE) ? in_idx : idx_q;
  assign rd_load = (state_d == RESP) && ((state_q == IDLE) ? !mem_write : !wr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!req) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp = (state_q == RESP);
  end

  assign mem_rdata = rdata_q;
  assign proto_err = perr_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= in_idx;
      wdata_q <= mem_wdata;
      wmask_q <= mem_wmask;
      wr_q    <= mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 16'h0000;
      perr_q  <= 1'b0;
    end else begin
      if (rd_load) rdata_q <= mem_q[rd_idx];
      if (accept && mem_read && mem_write) perr_q <= 1'b1;
    end
  end

  // Store is not reset; a reset landing on RESP suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RESP) && wr_q) begin
      if (wmask_q[0]) mem_q[idx_q][7:0]  <= wdata_q[7:0];
      if (wmask_q[1]) mem_q[idx_q][15:8] <= wdata_q[15:8];
    end
  end

`ifdef LC3B_MEM_STATS_EN
  logic [15:0] stat_rd_q, stat_wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q <= 16'h0000;
      stat_wr_q <= 16'h0000;
    end else if (state_q == RESP) begin
      if (wr_q) begin
        if (stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
      end else begin
        if (stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
      end
    end
  end

  assign stat_reads  = stat_rd_q;
  assign stat_writes = stat_wr_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// tb/tb_lc3b_mem_responder.sv - directed vector bench for lc3b_mem_responder
module tb_lc3b_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        proto_err;
`ifdef LC3B_MEM_STATS_EN
  logic [15:0] stat_reads, stat_writes;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lc3b_mem_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wmask   (mem_wmask),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .proto_err   (proto_err)
`ifdef LC3B_MEM_STATS_EN
    ,
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes)
`endif
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wmask   = 2'b00;
    mem_address = 16'h0000;
    mem_wdata   = 16'h0000;
  endtask

  // Called just after a rising edge with the DUT idle; request cycle is T.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] wm,
                        input logic [15:0] exp_rdata, input string name);
    int resp_cyc;
    resp_cyc    = -1;
    mem_read    = rd;
    mem_write   = wr;
    mem_address = addr;
    mem_wdata   = wd;
    mem_wmask   = wm;
    for (int c = 0; c <= 10 && resp_cyc < 0; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        resp_cyc = c;
        check({name, " rdata"}, int'(mem_rdata), int'(exp_rdata));
      end
    end
    check({name, " latency"}, resp_cyc, 4);
    idle_inputs();
    @(negedge clk);
    check({name, " resp pulse width"}, int'(mem_resp), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic watch_no_resp(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (mem_resp) seen++;
    end
    check({name, " no resp"}, seen, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0040, 16'h1234, 2'b11, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h1234};
    vecs[2]  = '{1'b0, 1'b1, 16'h0041, 16'hABCD, 2'b01, 16'h1234};
    vecs[3]  = '{1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h12CD};
    vecs[4]  = '{1'b0, 1'b1, 16'h0042, 16'h0000, 2'b11, 16'h12CD};
    vecs[5]  = '{1'b0, 1'b1, 16'h0043, 16'h5A5A, 2'b10, 16'h12CD};
    vecs[6]  = '{1'b1, 1'b0, 16'h0042, 16'h0000, 2'b00, 16'h5A00};
    vecs[7]  = '{1'b0, 1'b1, 16'h0040, 16'hFFFF, 2'b00, 16'h5A00};
    vecs[8]  = '{1'b1, 1'b0, 16'h0041, 16'h0000, 2'b00, 16'h12CD};
    vecs[9]  = '{1'b0, 1'b1, 16'h0802, 16'hBEEF, 2'b11, 16'h12CD};
    vecs[10] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 2'b00, 16'hBEEF};
    vecs[11] = '{1'b1, 1'b0, 16'h8040, 16'h0000, 2'b00, 16'h12CD};

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_resp", int'(mem_resp), 0);
    check("reset mem_rdata", int'(mem_rdata), 0);
    check("reset proto_err", int'(proto_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
             vecs[i].exp_rdata, $sformatf("vec%0d", i));
    end
    check("proto_err clean", int'(proto_err), 0);

    // Abort: request dropped during the first busy cycle.
    mem_read    = 1'b1;
    mem_address = 16'h0040;
    @(posedge clk);
    #1 mem_read = 1'b0;
    watch_no_resp("abort", 8);
    @(posedge clk);
    #1;
    do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h12CD, "post-abort read");

    // Read and write together: treated as a write, error flag sticks.
    do_txn(1'b1, 1'b1, 16'h0010, 16'h5555, 2'b11, 16'h12CD, "conflict");
    check("proto_err set", int'(proto_err), 1);
    do_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'h5555, "conflict readback");
    check("proto_err sticky", int'(proto_err), 1);
`ifdef LC3B_MEM_STATS_EN
    check("stat_reads", int'(stat_reads), 8);
    check("stat_writes", int'(stat_writes), 7);
`endif

    // Reset lands two cycles after a write is accepted.
    mem_write   = 1'b1;
    mem_address = 16'h0040;
    mem_wdata   = 16'hFFFF;
    mem_wmask   = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
    watch_no_resp("reset mid-write", 8);
    check("post-reset mem_rdata", int'(mem_rdata), 0);
    check("post-reset proto_err", int'(proto_err), 0);
    @(posedge clk);
    #1;
    do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h12CD, "post-reset read");
`ifdef LC3B_MEM_STATS_EN
    check("stat_reads after reset", int'(stat_reads), 1);
    check("stat_writes after reset", int'(stat_writes), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b datapath's memory port.
- Accepts the CPU's read and write requests (`mem_read`/`mem_write`/`mem_wmask`/`mem_address`/`mem_wdata`) and returns `mem_resp`/`mem_rdata` after a fixed, programmable latency.
- Backs a word-organised on-chip store with byte-write masking.
- Used as the simulation and FPGA memory behind the pipelined core.

Parameters:
- ADDR_WIDTH, 10, number of word-index bits; store depth = 2**ADDR_WIDTH 16-bit words.
- LATENCY, 4, cycles from request acceptance to `mem_resp`; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  read request; held by CPU until `mem_resp`
- mem_write  input  1  write request; held by CPU until `mem_resp`
- mem_wmask  input  2  byte enables for write; bit0 = low byte [7:0], bit1 = high byte [15:8]
- mem_address  input  16  byte address (lc3b_word)
- mem_wdata  input  16  write data (lc3b_word)
- mem_resp  output  1  one-cycle completion pulse
- mem_rdata  output  16  read data, valid in the `mem_resp` cycle
- proto_err  output  1  sticky flag: a protocol violation was seen

Behaviour:
- Reset state: `mem_resp`=0, `mem_rdata`=16'h0000, `proto_err`=0, FSM=IDLE, latency counter=0. Reset does not clear store contents.
- Address decode:
  - Word index = `mem_address[ADDR_WIDTH:1]`; `mem_address[0]` is ignored.
  - Address bits above ADDR_WIDTH are ignored, so addresses alias modulo 2**(ADDR_WIDTH+1) bytes.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `mem_read` or `mem_write` is high in cycle T, latch address, wdata, wmask and op.
  - Load counter with LATENCY-1 and go to BUSY. When LATENCY=1, go directly to RESP.
- BUSY:
  - Decrement the counter each cycle; when it reaches 0, go to RESP.
  - If `mem_read` and `mem_write` are both low for any BUSY cycle, abort: return to IDLE, no write, no `mem_resp`.
- RESP:
  - `mem_resp`=1 for exactly this cycle, which is cycle T+LATENCY.
  - Read: `mem_rdata` = store[latched index] in this cycle.
  - Write: store bytes updated per the latched wmask at the end of this cycle. `mem_rdata` is unchanged.
  - Next state is always IDLE.
- After RESP:
  - The first IDLE cycle is T+LATENCY+1. A request present then is a new transaction.
  - Back-to-back transactions therefore have a throughput of one per LATENCY+1 cycles.
- Captured values are authoritative. Changes to address, wdata or wmask after acceptance are ignored; only full deassertion aborts.
- `mem_rdata` holds its last read value between reads.
- `mem_wmask`=2'b00 on a write completes normally (`mem_resp` pulses) with no store change.
- `mem_read` and `mem_write` both high at acceptance: treated as a write, and `proto_err` is set (sticky until `rst`).
- Reset asserted mid-transaction:
  - FSM returns to IDLE and no response is issued.
  - A pending write is dropped. If `rst` coincides with the RESP cycle, the write is also suppressed.
- Store write and read in the same cycle cannot occur, since there is one transaction at a time.

Optional Feature:
- Macro: LC3B_MEM_STATS_EN.
- With the macro defined:
  - Extra outputs `stat_reads`[15:0] and `stat_writes`[15:0].
  - Each increments by 1 in the RESP cycle of a completed read or write respectively.
  - Aborted transactions are not counted.
  - Counters saturate at 16'hFFFF and reset to 0 on `rst`.
- Without the macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Full write then read: write 16'h1234 to 16'h0040, mask 2'b11; then read 16'h0040 → `mem_resp` exactly at accept+4 for each, `mem_rdata`=16'h1234 in the read's resp cycle.
- Byte mask: after the above, write 16'hABCD to 16'h0041, mask 2'b01; read 16'h0040 → 16'h12CD (bit0 of address ignored).
- Abort: issue read of 16'h0040, drop `mem_read` in the 2nd cycle → no `mem_resp` for 8 cycles; a following read completes at accept+4.
- Conflict: assert `mem_read` and `mem_write` together with wdata 16'h5555, mask 2'b11 at 16'h0010 → `proto_err`=1 and stays 1; a later read of 16'h0010 returns 16'h5555.
- Reset mid-write: write 16'hFFFF to 16'h0040, assert `rst` at accept+2 → no `mem_resp`; after reset, a read of 16'h0040 returns 16'h12CD; `mem_rdata` reads 0 immediately after reset, before any read completes.
- Aliasing and stats (LC3B_MEM_STATS_EN, ADDR_WIDTH=10): write 16'hBEEF at 16'h0802, read 16'h0002 → 16'hBEEF; `stat_writes`=1, `stat_reads`=1.
